// File: rtl/kbd_term_encoder.sv
// PS/2 scan-code (set 2) to terminal-event encoder: make/break, E0 prefix,
// Shift/Caps tracking and a small event FIFO drained by the display.
module kbd_term_encoder #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_ready,
   input  logic [7:0] ps2_data,
   output logic       ps2_nextdata_n,
   input  logic       take,
   output logic       no_input,
   output logic [2:0] command,
   output logic [7:0] char_ascii,
   output logic       caps_on,
   output logic       overflow
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [2:0]   CMD_CHAR = 3'd0;
   localparam logic [2:0]   CMD_ENTER = 3'd1;
   localparam logic [2:0]   CMD_BKSP = 3'd2;

   typedef enum logic [1:0] {S_IDLE, S_POP, S_DECODE} state_t;

   state_t            r_state;
   logic [7:0]        r_byte;
   logic              r_brk, r_ext, r_shift_l, r_shift_r, r_caps, r_overflow;
   logic [10:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [AW:0]       r_count;

   logic [8:0]        w_map;
   logic              w_key, w_push, w_empty, w_full, w_do_push, w_do_take;
   logic [10:0]       w_entry, w_head;

   // Returns {hit, ascii}. Letters honour shift^caps; everything else shift only.
   function automatic logic [8:0] map_key(input logic [7:0] code, input logic shift,
                                          input logic caps);
      logic [7:0] lc, un, sh;
      lc = 8'h00; un = 8'h00; sh = 8'h00;
      case (code)
         8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
         8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
         8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
         8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
         8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
         8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
         8'h35: lc = "y";  8'h1A: lc = "z";
         8'h16: begin un = "1"; sh = "!"; end
         8'h1E: begin un = "2"; sh = "@"; end
         8'h26: begin un = "3"; sh = "#"; end
         8'h25: begin un = "4"; sh = "$"; end
         8'h2E: begin un = "5"; sh = "%"; end
         8'h36: begin un = "6"; sh = "^"; end
         8'h3D: begin un = "7"; sh = "&"; end
         8'h3E: begin un = "8"; sh = "*"; end
         8'h46: begin un = "9"; sh = "("; end
         8'h45: begin un = "0"; sh = ")"; end
         8'h0E: begin un = 8'h60; sh = "~"; end
         8'h4E: begin un = "-"; sh = "_"; end
         8'h55: begin un = "="; sh = "+"; end
         8'h54: begin un = "["; sh = "{"; end
         8'h5B: begin un = "]"; sh = "}"; end
         8'h5D: begin un = 8'h5C; sh = 8'h7C; end
         8'h4C: begin un = ";"; sh = ":"; end
         8'h52: begin un = 8'h27; sh = 8'h22; end
         8'h41: begin un = ","; sh = "<"; end
         8'h49: begin un = "."; sh = ">"; end
         8'h4A: begin un = "/"; sh = "?"; end
         8'h29: begin un = " "; sh = " "; end
         default: ;
      endcase
      if (lc != 8'h00)      return {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
      else if (un != 8'h00) return {1'b1, shift ? sh : un};
      else                  return 9'h000;
   endfunction

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_map   = map_key(r_byte, r_shift_l | r_shift_r, r_caps);
      w_key   = (r_state == S_DECODE) && (r_byte != 8'hF0) && (r_byte != 8'hE0);
      w_push  = 1'b0;
      w_entry = 11'h000;
      if (w_key && !r_brk) begin
         if (r_byte == 8'h5A) begin
            w_push  = 1'b1;
            w_entry = {CMD_ENTER, 8'h00};
         end else if (!r_ext) begin
            if (r_byte == 8'h66) begin
               w_push  = 1'b1;
               w_entry = {CMD_BKSP, 8'h00};
            end else if (w_map[8]) begin
               w_push  = 1'b1;
               w_entry = {CMD_CHAR, w_map[7:0]};
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (clrn) begin
         r_state   <= S_IDLE;
         r_byte    <= 8'h00;
         r_brk     <= 1'b0;
         r_ext     <= 1'b0;
         r_shift_l <= 1'b0;
         r_shift_r <= 1'b0;
         r_caps    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (ps2_ready) begin
               r_byte  <= ps2_data;
               r_state <= S_POP;
            end
            S_POP: r_state <= S_DECODE;
            S_DECODE: begin
               r_state <= S_IDLE;
               if (r_byte == 8'hF0)      r_brk <= 1'b1;
               else if (r_byte == 8'hE0) r_ext <= 1'b1;
               else begin
                  r_brk <= 1'b0;
                  r_ext <= 1'b0;
                  if (r_brk) begin
                     if (r_byte == 8'h12) r_shift_l <= 1'b0;
                     if (r_byte == 8'h59) r_shift_r <= 1'b0;
                  end else if (!r_ext) begin
                     if (r_byte == 8'h12) r_shift_l <= 1'b1;
                     if (r_byte == 8'h59) r_shift_r <= 1'b1;
                     if (r_byte == 8'h58) r_caps    <= ~r_caps;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_do_take = take & ~w_empty;
   assign w_do_push = w_push & (~w_full | w_do_take);

   always_ff @(posedge clk) begin
      if (clrn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_take) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_take})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: ;
         endcase
         if (w_push && !w_do_push) r_overflow <= 1'b1;
      end
   end

   // NOTE: storage is not reset; pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push && !clrn) r_mem[r_wr_ptr] <= w_entry;
   end

   assign w_head         = r_mem[r_rd_ptr];
   assign no_input       = w_empty;
   assign command        = w_empty ? 3'd0  : w_head[10:8];
   assign char_ascii     = w_empty ? 8'h00 : w_head[7:0];
   assign caps_on        = r_caps;
   assign overflow       = r_overflow;
   // Reset during POP suppresses the strobe so the receiver keeps its byte.
   assign ps2_nextdata_n = ~((r_state == S_POP) & ~clrn);

endmodule

// File: tb/tb_kbd_term_encoder.sv
// Directed self-checking bench for kbd_term_encoder: decode, prefixes,
// shift/caps, FIFO full/overflow, same-cycle push/take and mid-byte reset.
module tb_kbd_term_encoder;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       clrn = 1'b1;
   logic       ps2_ready = 1'b0;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_nextdata_n;
   logic       take = 1'b0;
   logic       no_input;
   logic [2:0] command;
   logic [7:0] char_ascii;
   logic       caps_on;
   logic       overflow;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int p0;

   kbd_term_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
      .ps2_nextdata_n(ps2_nextdata_n), .take(take), .no_input(no_input),
      .command(command), .char_ascii(char_ascii), .caps_on(caps_on),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ps2_nextdata_n === 1'b0) pulse_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clrn = 1'b1;
      repeat (2) cycle();
      clrn = 1'b0;
   endtask

   // Receiver model: byte offered until the pop strobe, then withdrawn.
   task automatic send(input logic [7:0] b);
      ps2_ready = 1'b1;
      ps2_data  = b;
      cycle();
      check("pop_strobe_low", ps2_nextdata_n, 1'b0);
      ps2_ready = 1'b0;
      cycle();
      check("strobe_high_in_decode", ps2_nextdata_n, 1'b1);
      cycle();
   endtask

   task automatic expect_event(input string tag, input logic [2:0] cmd, input logic [7:0] asc);
      check({tag, "_present"}, no_input, 1'b0);
      check({tag, "_cmd"}, command, cmd);
      check({tag, "_ascii"}, char_ascii, asc);
      take = 1'b1;
      cycle();
      take = 1'b0;
   endtask

   initial begin
      repeat (2) cycle();
      check("rst_nextdata_n", ps2_nextdata_n, 1'b1);
      check("rst_no_input", no_input, 1'b1);
      check("rst_command", command, 3'd0);
      check("rst_char_ascii", char_ascii, 8'h00);
      check("rst_caps_on", caps_on, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      clrn = 1'b0;
      cycle();

      // Make/break of 'a'
      p0 = pulse_cnt;
      send(8'h1C); send(8'hF0); send(8'h1C);
      check("three_pops", pulse_cnt - p0, 3);
      expect_event("a_make", 3'd0, 8'h61);
      check("break_no_event", no_input, 1'b1);

      // Shift, caps and their XOR
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
      expect_event("shift_a", 3'd0, 8'h41);
      expect_event("unshift_a", 3'd0, 8'h61);
      check("shift_seq_drained", no_input, 1'b1);
      send(8'h58);
      check("caps_set", caps_on, 1'b1);
      send(8'h1C);
      expect_event("caps_a", 3'd0, 8'h41);
      send(8'h12); send(8'h1C);
      expect_event("caps_shift_a", 3'd0, 8'h61);
      send(8'h12); send(8'h16);
      expect_event("shift_1", 3'd0, 8'h21);
      send(8'hF0); send(8'h12); send(8'h58);
      check("caps_cleared", caps_on, 1'b0);
      check("caps_release_no_event", no_input, 1'b1);

      // Control keys, extended codes and other map entries
      send(8'h5A);
      expect_event("enter", 3'd1, 8'h00);
      send(8'hE0); send(8'h5A);
      expect_event("kp_enter", 3'd1, 8'h00);
      send(8'h66);
      expect_event("backspace", 3'd2, 8'h00);
      send(8'hE0); send(8'h75);
      check("ext_up_discarded", no_input, 1'b1);
      send(8'h45);
      expect_event("digit_0", 3'd0, 8'h30);
      send(8'h4E);
      expect_event("minus", 3'd0, 8'h2D);
      send(8'h1A);
      expect_event("z", 3'd0, 8'h7A);
      send(8'h12); send(8'h29); send(8'hF0); send(8'h12);
      expect_event("shift_space", 3'd0, 8'h20);

      // Take on empty FIFO is ignored
      take = 1'b1;
      cycle();
      take = 1'b0;
      send(8'h32);
      expect_event("after_empty_take", 3'd0, 8'h62);
      check("after_empty_take_drained", no_input, 1'b1);

      // Overflow: DEPTH+1 pushes with no take
      for (int i = 0; i < DEPTH + 1; i++) send(8'h1C);
      check("full_present", no_input, 1'b0);
      check("overflow_set", overflow, 1'b1);
      take = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_present", no_input, 1'b0);
         check("drain_ascii", char_ascii, 8'h61);
         cycle();
      end
      take = 1'b0;
      check("drained_empty", no_input, 1'b1);
      check("overflow_sticky", overflow, 1'b1);

      // Full FIFO with simultaneous push and take
      do_reset();
      check("overflow_reset", overflow, 1'b0);
      for (int i = 0; i < DEPTH; i++) send(8'h1C);
      check("full_no_overflow", overflow, 1'b0);
      ps2_ready = 1'b1;
      ps2_data  = 8'h32;
      cycle();
      ps2_ready = 1'b0;
      cycle();
      take = 1'b1;
      cycle();
      take = 1'b0;
      check("push_take_overflow", overflow, 1'b0);
      take = 1'b1;
      repeat (DEPTH - 1) cycle();
      check("push_take_last_present", no_input, 1'b0);
      check("push_take_last_is_b", char_ascii, 8'h62);
      cycle();
      take = 1'b0;
      check("push_take_count", no_input, 1'b1);

      // Reset during DECODE with caps on and queued events
      send(8'h58);
      send(8'h1C); send(8'h1C); send(8'h1C);
      check("pre_rst_caps", caps_on, 1'b1);
      check("pre_rst_ascii", char_ascii, 8'h41);
      ps2_ready = 1'b1;
      ps2_data  = 8'h1C;
      cycle();
      ps2_ready = 1'b0;
      cycle();
      clrn = 1'b1;
      cycle();
      check("mid_rst_no_input", no_input, 1'b1);
      check("mid_rst_caps", caps_on, 1'b0);
      check("mid_rst_overflow", overflow, 1'b0);
      check("mid_rst_nextdata_n", ps2_nextdata_n, 1'b1);
      clrn = 1'b0;
      repeat (3) cycle();
      check("mid_rst_no_event", no_input, 1'b1);

      // Reset landing in POP suppresses the strobe
      ps2_ready = 1'b1;
      ps2_data  = 8'h1C;
      cycle();
      clrn = 1'b1;
      #1;
      check("pop_rst_no_strobe", ps2_nextdata_n, 1'b1);
      ps2_ready = 1'b0;
      cycle();
      clrn = 1'b0;
      repeat (3) cycle();
      check("pop_rst_no_event", no_input, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
